// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx_in, qualifies the start bit at mid-bit and samples
// each bit at its centre, producing a one-cycle valid strobe or framing-error strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic             rx_s;
  logic [CNT_W-1:0] clk_cnt_r, clk_cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [7:0]       shift_r, shift_s;
  logic [7:0]       data_s;
  logic             valid_s, ferr_s;

  // Synchroniser flops reset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s = sync_r[SYNC_STAGES-1];

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      clk_cnt_r <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      state_r   <= state_s;
      clk_cnt_r <= clk_cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      rx_data   <= data_s;
      rx_valid  <= valid_s;
      frame_err <= ferr_s;
      rx_busy   <= (state_s != ST_IDLE);
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_s   = state_r;
    clk_cnt_s = clk_cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    data_s    = rx_data;
    valid_s   = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          clk_cnt_s = '0;
          state_s   = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (clk_cnt_r == CNT_HALF) begin
          clk_cnt_s = '0;
          bit_idx_s = 3'd0;
          // A line that is high again at mid-start was only a glitch.
          state_s   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (clk_cnt_r == CNT_MAX) begin
          clk_cnt_s = '0;
          shift_s   = {rx_s, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (clk_cnt_r == CNT_MAX) begin
          clk_cnt_s = '0;
          if (rx_s) begin
            data_s  = shift_r;
            valid_s = 1'b1;
            state_s = ST_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = ST_BRK;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_W'(1);
        end
      end
      ST_BRK: begin
        // Held-low line: stay here so only one frame_err is reported.
        if (rx_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BRK;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        clk_cnt_s = '0;
        bit_idx_s = 3'd0;
      end
    endcase
  end

endmodule
